store_merge: RTL and testbench
==============================

Name: store_merge

Overview:
- Store-path counterpart of the load-side sign/zero extender: narrows a 32-bit register value to byte, halfword or word and splices it into the addressed memory word.
- Data memory has no byte enables, so sub-word stores run read-modify-write; aligned word stores write directly.
- Sits between the MEM-stage store request and the data-memory port. Flags misaligned or illegal stores without touching memory.

Parameters:
- ADDR_W, 32, byte-address width.
- BIG_ENDIAN, 0, byte-lane order: 0 = byte at addr[1:0]=0 is bits 7:0; 1 = bits 31:24.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  store request present.
- req_ready  out  1  block can accept a request (IDLE only).
- req_addr  in  ADDR_W  byte address.
- req_data  in  32  store data, low bits significant for SB/SH.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- done  out  1  one-cycle pulse: store committed to memory.
- misalign  out  1  one-cycle pulse: request rejected, no memory access.
- mem_addr  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2],2'b00}.
- mem_rd  out  1  read command.
- mem_wr  out  1  write command.
- mem_ready  in  1  memory accepts the current mem_rd/mem_wr this cycle.
- mem_rdata  in  32  read data.
- mem_rvalid  in  1  mem_rdata valid.
- mem_wdata  out  32  merged write word.

Behaviour:
- Reset (rst high at a clock edge): state=IDLE. mem_rd, mem_wr, done, misalign = 0. mem_addr and mem_wdata = 0. req_ready = 0 while rst is high, 1 in the first IDLE cycle after. Reset mid-operation aborts immediately: no done, and any pending command is dropped.
- States: IDLE, FAULT, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE: req_ready=1. On req_valid, latch addr, data and size, then:
  - misaligned or illegal (size 11; half with addr[0]=1; word with addr[1:0]!=0) -> FAULT;
  - word -> WR_REQ with wdata=req_data;
  - byte or half -> RD_REQ.
- FAULT: misalign=1 for exactly one cycle -> IDLE.
- RD_REQ: mem_rd=1, mem_addr held stable until mem_ready=1 -> RD_WAIT.
- RD_WAIT: mem_rvalid is sampled only here. On the cycle it is high, register the merged word -> WR_REQ.
- Merge: lane = addr[1:0] XOR (BIG_ENDIAN ? 2'b11 : 2'b00).
  - Byte: req_data[7:0] replaces lane bits [8*lane+7 : 8*lane].
  - Half: addr[1] selects a halfword (BIG_ENDIAN flips the half index); req_data[15:0] replaces that half.
  - All other bits come from mem_rdata. req_data upper bits are ignored.
- WR_REQ: mem_wr=1, mem_wdata and mem_addr stable until mem_ready=1 -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- mem_rd and mem_wr are never asserted together. mem_rvalid outside RD_WAIT is ignored. New requests are not accepted outside IDLE.
- Latency with mem_ready=1 and same-cycle rvalid, counted from the accept edge:
  - word store: done 2 cycles later;
  - sub-word store: done 4 cycles later;
  - fault: misalign 1 cycle later.
- Each cycle of mem_ready low or rvalid low adds one cycle.

Test Plan:
- LE, memory[0x100]=0x11223344; SB addr 0x102 data 0xFFFFFFAB -> one mem_rd @0x100, then mem_wr @0x100 wdata 0x11AB3344, done 4 cycles after accept.
- LE, same memory; SH addr 0x102 data 0x0000BEEF -> wdata 0xBEEF3344. SH addr 0x100 -> wdata 0x1122BEEF.
- SW addr 0x104 data 0xDEADBEEF -> no mem_rd, mem_wr @0x104 wdata 0xDEADBEEF, done 2 cycles after accept. SH addr 0x101, SW addr 0x106, and size=11 each -> misalign pulse, mem_rd=mem_wr=0, req_ready back 2 cycles after accept.
- BIG_ENDIAN=1, memory 0x11223344; SB addr 0x100 data 0xAB -> wdata 0xAB223344. SH addr 0x102 data 0xBEEF -> wdata 0x1122BEEF.
- SB with mem_ready low 3 cycles in RD_REQ and mem_rvalid delayed 2 cycles -> mem_rd held with stable address, correct merge, done 9 cycles after accept. A stray rvalid pulse in IDLE is ignored.
- rst asserted during RD_WAIT -> next cycle all outputs 0, no mem_wr and no done issued. A following SW completes normally.

Source files
------------

// File: rtl/store_merge.sv
// Store-side data narrower: splices byte/halfword stores into the addressed memory
// word by read-modify-write, writes aligned words directly, and rejects misaligned stores.
module store_merge #(
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              done,
  output logic              misalign,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic [31:0]       mem_wdata
);

  typedef enum logic [2:0] {
    IDLE, FAULT, RD_REQ, RD_WAIT, WR_REQ, DONE
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t            state_reg;
  logic [1:0]        offs_reg;
  logic [15:0]       data_reg;
  logic [1:0]        size_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [31:0]       wdata_reg;
  logic              mem_rd_reg;
  logic              mem_wr_reg;
  logic              done_reg;
  logic              misalign_reg;

  logic        bad_req;
  logic [1:0]  lane_idx;
  logic        half_idx;
  logic [31:0] merged;

  assign bad_req = (req_size == 2'b11) ||
                   ((req_size == SZ_HALF) && req_addr[0]) ||
                   ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

  // Lane numbers count bit positions (lane 0 = bits 7:0); big-endian mirrors the byte offset.
  assign lane_idx = offs_reg ^ (BIG_ENDIAN ? 2'b11 : 2'b00);
  assign half_idx = offs_reg[1] ^ BIG_ENDIAN;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      localparam bit         HI   = (gi % 2) == 1;
      logic       hit;
      logic [7:0] new_byte;
      assign hit      = (size_reg == SZ_BYTE) ? (lane_idx == LANE) : (half_idx == LANE[1]);
      assign new_byte = ((size_reg != SZ_BYTE) && HI) ? data_reg[15:8] : data_reg[7:0];
      assign merged[8*gi +: 8] = hit ? new_byte : mem_rdata[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      offs_reg     <= 2'b00;
      data_reg     <= 16'h0;
      size_reg     <= 2'b00;
      mem_addr_reg <= '0;
      wdata_reg    <= 32'h0;
      mem_rd_reg   <= 1'b0;
      mem_wr_reg   <= 1'b0;
      done_reg     <= 1'b0;
      misalign_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            offs_reg <= req_addr[1:0];
            data_reg <= req_data[15:0];
            size_reg <= req_size;
            if (bad_req) begin
              misalign_reg <= 1'b1;
              state_reg    <= FAULT;
            end else begin
              mem_addr_reg <= {req_addr[ADDR_W-1:2], 2'b00};
              if (req_size == SZ_WORD) begin
                wdata_reg  <= req_data;
                mem_wr_reg <= 1'b1;
                state_reg  <= WR_REQ;
              end else begin
                mem_rd_reg <= 1'b1;
                state_reg  <= RD_REQ;
              end
            end
          end
        end
        FAULT: begin
          misalign_reg <= 1'b0;
          state_reg    <= IDLE;
        end
        RD_REQ: begin
          if (mem_ready) begin
            mem_rd_reg <= 1'b0;
            state_reg  <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // Read data is only trusted here; stray rvalid elsewhere never reaches the merge.
          if (mem_rvalid) begin
            wdata_reg  <= merged;
            mem_wr_reg <= 1'b1;
            state_reg  <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (mem_ready) begin
            mem_wr_reg <= 1'b0;
            done_reg   <= 1'b1;
            state_reg  <= DONE;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_reg == IDLE) && !rst;
  assign done      = done_reg;
  assign misalign  = misalign_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_rd    = mem_rd_reg;
  assign mem_wr    = mem_wr_reg;
  assign mem_wdata = wdata_reg;

endmodule

// File: tb/tb_store_merge.sv
// Drives a little-endian and a big-endian store_merge with the same request stream
// and checks commands, merged words and cycle timing against a byte-array model.
module tb_store_merge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;

  logic        ready [2];
  logic        done_o [2];
  logic        mis_o [2];
  logic [31:0] maddr [2];
  logic        mrd [2];
  logic        mwr [2];
  logic [31:0] mwdata [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  store_merge #(.ADDR_W(32), .BIG_ENDIAN(1'b0)) u_le (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready[0]),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .done(done_o[0]), .misalign(mis_o[0]), .mem_addr(maddr[0]),
    .mem_rd(mrd[0]), .mem_wr(mwr[0]), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_wdata(mwdata[0])
  );

  store_merge #(.ADDR_W(32), .BIG_ENDIAN(1'b1)) u_be (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready[1]),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .done(done_o[1]), .misalign(mis_o[1]), .mem_addr(maddr[1]),
    .mem_rd(mrd[1]), .mem_wr(mwr[1]), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_wdata(mwdata[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Memory viewed as bytes in address order; a store overwrites consecutive bytes,
  // most significant data byte first on big-endian.
  function automatic logic [31:0] model(input logic [31:0] old, input logic [1:0] off,
                                        input logic [31:0] data, input logic [1:0] size,
                                        input bit be);
    logic [7:0]  b [4];
    logic [31:0] w;
    int n;
    for (int i = 0; i < 4; i++) b[i] = be ? old[8*(3-i) +: 8] : old[8*i +: 8];
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    for (int k = 0; k < n; k++)
      b[int'(off) + k] = be ? data[8*(n-1-k) +: 8] : data[8*k +: 8];
    for (int i = 0; i < 4; i++) begin
      if (be) w[8*(3-i) +: 8] = b[i];
      else    w[8*i +: 8]     = b[i];
    end
    return w;
  endfunction

  task automatic run_store(input string nm, input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] size, input logic [31:0] old,
                           input int srd, input int rvd, input int swr,
                           input logic [31:0] exp_le, input logic [31:0] exp_be);
    bit          fault, waiting;
    int          exp_end, rd_n, wait_n, wr_n;
    int          rd_cnt [2];
    int          wr_cnt [2];
    logic [31:0] exp_w [2];
    logic [31:0] waddr;
    fault   = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    exp_end = fault ? 1 : (size == 2'b10) ? 2 + swr : 4 + srd + rvd + swr;
    exp_w[0] = exp_le;
    exp_w[1] = exp_be;
    waddr   = {addr[31:2], 2'b00};
    rd_n = 0; wr_n = 0; wait_n = 0; waiting = 1'b0;
    rd_cnt = '{0, 0};
    wr_cnt = '{0, 0};
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk({nm, " ready_idle"}, 32'(ready[d]), 32'd1);
    req_valid  = 1'b1; req_addr = addr; req_data = data; req_size = size;
    mem_ready  = 1'($urandom); mem_rvalid = 1'($urandom); mem_rdata = $urandom;
    for (int k = 1; k <= exp_end; k++) begin
      @(negedge clk);
      // Keep offering junk requests while busy; none may be accepted.
      req_addr = $urandom; req_data = $urandom; req_size = 2'($urandom);
      mem_ready = 1'($urandom); mem_rvalid = 1'($urandom); mem_rdata = $urandom;
      for (int d = 0; d < 2; d++) begin
        chk({nm, " ready_busy"}, 32'(ready[d]), 32'd0);
        chk({nm, " rd_wr_excl"}, 32'(mrd[d] & mwr[d]), 32'd0);
        chk({nm, " done"}, 32'(done_o[d]), 32'(!fault && k == exp_end));
        chk({nm, " misalign"}, 32'(mis_o[d]), 32'(fault && k == exp_end));
        if (mrd[d]) begin
          rd_cnt[d]++;
          chk({nm, " rd_addr"}, maddr[d], waddr);
        end
        if (mwr[d]) begin
          wr_cnt[d]++;
          chk({nm, " wr_addr"}, maddr[d], waddr);
          chk({nm, d == 0 ? " wdata_le" : " wdata_be"}, mwdata[d], exp_w[d]);
        end
      end
      if (waiting) begin
        if (wait_n == rvd) begin
          mem_rvalid = 1'b1; mem_rdata = old; waiting = 1'b0;
        end else begin
          mem_rvalid = 1'b0; wait_n++;
        end
      end else if (mrd[0]) begin
        rd_n++;
        mem_ready = (rd_n > srd);
        waiting   = mem_ready;
      end else if (mwr[0]) begin
        wr_n++;
        mem_ready = (wr_n > swr);
      end
      if (k == exp_end) req_valid = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      chk({nm, " rd_count"}, 32'(rd_cnt[d]), (fault || size == 2'b10) ? 32'd0 : 32'(srd + 1));
      chk({nm, " wr_count"}, 32'(wr_cnt[d]), fault ? 32'd0 : 32'(swr + 1));
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk({nm, " ready_after"}, 32'(ready[d]), 32'd1);
      chk({nm, " quiet_after"}, {28'd0, done_o[d], mis_o[d], mrd[d], mwr[d]}, 32'd0);
    end
    $display("store %s addr=%h data=%h size=%0d -> le=%h be=%h end=%0d", nm, addr, data, size,
             mwdata[0], mwdata[1], exp_end);
    // Stray rvalid while idle must be ignored.
    mem_rvalid = 1'b1; mem_rdata = $urandom;
  endtask

  typedef struct {
    string       nm;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [31:0] old;
    int          srd, rvd, swr;
    logic [31:0] exp_le, exp_be;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [31:0] a, dt, od;
    logic [1:0]  sz;
    vecs[0] = '{"sb_102",     32'h102, 32'hFFFFFFAB, 2'd0, 32'h11223344, 0, 0, 0, 32'h11AB3344, 32'h1122AB44};
    vecs[1] = '{"sh_102",     32'h102, 32'h0000BEEF, 2'd1, 32'h11223344, 0, 0, 0, 32'hBEEF3344, 32'h1122BEEF};
    vecs[2] = '{"sh_100",     32'h100, 32'h0000BEEF, 2'd1, 32'h11223344, 0, 0, 0, 32'h1122BEEF, 32'hBEEF3344};
    vecs[3] = '{"sw_104",     32'h104, 32'hDEADBEEF, 2'd2, 32'h0,        0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[4] = '{"sh_101_bad", 32'h101, 32'h0000BEEF, 2'd1, 32'h0,        0, 0, 0, 32'h0,        32'h0};
    vecs[5] = '{"sw_106_bad", 32'h106, 32'hDEADBEEF, 2'd2, 32'h0,        0, 0, 0, 32'h0,        32'h0};
    vecs[6] = '{"sz11_bad",   32'h100, 32'h12345678, 2'd3, 32'h0,        0, 0, 0, 32'h0,        32'h0};
    vecs[7] = '{"sb_100",     32'h100, 32'h000000AB, 2'd0, 32'h11223344, 0, 0, 0, 32'h112233AB, 32'hAB223344};
    vecs[8] = '{"sb_103_slow",32'h103, 32'hCAFE005A, 2'd0, 32'h11223344, 3, 2, 0, 32'h5A223344, 32'h1122335A};
    vecs[9] = '{"sw_108_slow",32'h108, 32'h01020304, 2'd2, 32'h0,        0, 0, 2, 32'h01020304, 32'h01020304};

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
    mem_ready = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_ready", 32'(ready[d]), 32'd0);
      chk("reset_ctl", {28'd0, done_o[d], mis_o[d], mrd[d], mwr[d]}, 32'd0);
      chk("reset_addr", maddr[d], 32'd0);
      chk("reset_wdata", mwdata[d], 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("ready_after_reset", 32'(ready[d]), 32'd1);

    for (int i = 0; i < 10; i++)
      run_store(vecs[i].nm, vecs[i].addr, vecs[i].data, vecs[i].size, vecs[i].old,
                vecs[i].srd, vecs[i].rvd, vecs[i].swr, vecs[i].exp_le, vecs[i].exp_be);

    // Reset while waiting for read data: everything drops, no write or done follows.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h100; req_data = 32'h55; req_size = 2'd0;
    mem_ready = 1'b1; mem_rvalid = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h11223344;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("midrst_ctl", {27'd0, ready[d], done_o[d], mis_o[d], mrd[d], mwr[d]}, 32'd0);
      chk("midrst_addr", maddr[d], 32'd0);
      chk("midrst_wdata", mwdata[d], 32'd0);
    end
    rst = 1'b0; mem_rvalid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) chk("midrst_quiet", {28'd0, done_o[d], mwr[d], mrd[d], ~ready[d]}, 32'd0);
    end
    $display("store midrst: reset during RD_WAIT aborted cleanly");
    run_store("sw_after_rst", 32'h200, 32'hA5A5F00D, 2'd2, 32'h0, 0, 0, 0, 32'hA5A5F00D, 32'hA5A5F00D);

    for (int i = 0; i < 60; i++) begin
      a  = $urandom & 32'hFFFF_FFFF;
      dt = $urandom;
      od = $urandom;
      sz = 2'($urandom_range(0, 3));
      run_store("rand", a, dt, sz, od, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), model(od, a[1:0], dt, sz, 1'b0), model(od, a[1:0], dt, sz, 1'b1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors + 1);
    $fatal(1, "timeout");
  end

endmodule
